fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the decode stage.
- Owns the PC and drives the word address to the combinational instruction memory.
- Captures PC, PC+4 and the instruction word into the IF/DEC pipeline register, with a valid bit.
- Honours stall requests from the hazard unit and taken-branch/jump redirects resolved in EX.

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads the IF/DEC register.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetched/squashed/stalled event counters.
module fetch_stage #(
  parameter int unsigned        DBITS               = 32,
  parameter logic [DBITS-1:0]   START_PC            = 32'h40,
  parameter int unsigned        IMEM_ADDR_BIT_WIDTH = 11,
  parameter logic [DBITS-1:0]   NOP_INST            = 32'h0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
  input  logic [DBITS-1:0]               imem_data,
  input  logic                           stall,
  input  logic                           redirect,
  input  logic [DBITS-1:0]               redirect_pc,
  output logic [DBITS-1:0]               fetch_pc,
  output logic                           dec_valid,
  output logic [DBITS-1:0]               dec_pc,
  output logic [DBITS-1:0]               dec_pc_inc,
  output logic [DBITS-1:0]               dec_inst,
  output logic                           misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DBITS-1:0]               perf_fetched,
  output logic [DBITS-1:0]               perf_squashed,
  output logic [DBITS-1:0]               perf_stalled
`endif
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [DBITS-1:0] dec_pc_q, dec_pc_d;
  logic [DBITS-1:0] dec_pc_inc_q, dec_pc_inc_d;
  logic [DBITS-1:0] dec_inst_q, dec_inst_d;
  logic             dec_valid_q, dec_valid_d;
  logic             misalign_q, misalign_d;
  logic [DBITS-1:0] pc_inc;

  assign pc_inc = pc_q + DBITS'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dec_pc_d     = dec_pc_q;
    dec_pc_inc_d = dec_pc_inc_q;
    dec_inst_d   = dec_inst_q;
    dec_valid_d  = dec_valid_q;
    misalign_d   = misalign_q;
    if (redirect) begin
      state_d      = ST_SQUASH;
      pc_d         = {redirect_pc[DBITS-1:2], 2'b00};
      dec_valid_d  = 1'b0;
      dec_pc_d     = '0;
      dec_pc_inc_d = '0;
      dec_inst_d   = NOP_INST;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (stall) begin
      state_d = ST_HOLD;
      // A stall landing on the squash cycle keeps the bubble in place.
      if (state_q == ST_SQUASH) dec_valid_d = 1'b0;
    end else begin
      state_d      = ST_RUN;
      pc_d         = pc_inc;
      dec_pc_d     = pc_q;
      dec_pc_inc_d = pc_inc;
      dec_inst_d   = imem_data;
      dec_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= START_PC;
      dec_pc_q     <= '0;
      dec_pc_inc_q <= '0;
      dec_inst_q   <= NOP_INST;
      dec_valid_q  <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dec_pc_q     <= dec_pc_d;
      dec_pc_inc_q <= dec_pc_inc_d;
      dec_inst_q   <= dec_inst_d;
      dec_valid_q  <= dec_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // Upper PC bits are dropped on purpose: the memory aliases beyond its depth.
  assign imem_addr    = pc_q[IMEM_ADDR_BIT_WIDTH+1:2];
  assign fetch_pc     = pc_q;
  assign dec_valid    = dec_valid_q;
  assign dec_pc       = dec_pc_q;
  assign dec_pc_inc   = dec_pc_inc_q;
  assign dec_inst     = dec_inst_q;
  assign misalign_err = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [DBITS-1:0] fetched_q, squashed_q, stalled_q;

  function automatic logic [DBITS-1:0] sat_inc(input logic [DBITS-1:0] v);
    return (&v) ? v : v + DBITS'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q  <= '0;
      squashed_q <= '0;
      stalled_q  <= '0;
    end else if (redirect) begin
      squashed_q <= sat_inc(squashed_q);
    end else if (stall) begin
      stalled_q  <= sat_inc(stalled_q);
    end else begin
      fetched_q  <= sat_inc(fetched_q);
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
  assign perf_stalled  = stalled_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts every post-edge snapshot.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0;

  logic        clk, reset, stall, redirect;
  logic [31:0] redirect_pc, imem_data, fetch_pc, dec_pc, dec_pc_inc, dec_inst;
  logic [10:0] imem_addr;
  logic        dec_valid, misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, perf_stalled;
`endif

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_pc_inc(dec_pc_inc), .dec_inst(dec_inst), .misalign_err(misalign_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_stalled(perf_stalled)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory: word at address a holds 0x11110000 + a.
  assign imem_data = 32'h11110000 + {21'd0, imem_addr};

  function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
    return 32'h11110000 + (byte_pc >> 2) % 2048;
  endfunction

  typedef struct {
    logic [31:0] pc, dpc, dinc, dinst, pf, ps, pt;
    logic        valid, err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Architectural model state.
  logic [31:0] m_pc, m_dpc, m_dinc, m_dinst, m_pf, m_ps, m_pt;
  logic        m_valid, m_err;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_pc = 32'h40; m_dpc = 0; m_dinc = 0; m_dinst = NOP; m_valid = 0; m_err = 0;
    m_pf = 0; m_ps = 0; m_pt = 0;
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    exp_t e;
    stall = st; redirect = rd; redirect_pc = rpc;
    if (rd) begin
      m_pc = rpc & ~32'h3;
      m_valid = 0; m_dpc = 0; m_dinc = 0; m_dinst = NOP;
      if (rpc[1:0] != 2'b00) m_err = 1;
      m_ps = sat(m_ps);
    end else if (st) begin
      m_pt = sat(m_pt);
    end else begin
      m_dpc = m_pc; m_dinc = m_pc + 4; m_dinst = mem_word(m_pc); m_valid = 1;
      m_pc = m_pc + 4;
      m_pf = sat(m_pf);
    end
    e.pc = m_pc; e.dpc = m_dpc; e.dinc = m_dinc; e.dinst = m_dinst;
    e.valid = m_valid; e.err = m_err; e.pf = m_pf; e.ps = m_ps; e.pt = m_pt;
    sb.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic check_reset_values();
    cmp("rst_fetch_pc", fetch_pc, 32'h40);
    cmp("rst_imem_addr", {21'd0, imem_addr}, 32'h10);
    cmp("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    cmp("rst_dec_pc", dec_pc, 32'd0);
    cmp("rst_dec_pc_inc", dec_pc_inc, 32'd0);
    cmp("rst_dec_inst", dec_inst, NOP);
    cmp("rst_misalign", {31'd0, misalign_err}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    cmp("rst_perf_fetched", perf_fetched, 32'd0);
    cmp("rst_perf_squashed", perf_squashed, 32'd0);
    cmp("rst_perf_stalled", perf_stalled, 32'd0);
`endif
  endtask

  task automatic random_steps(input int n);
    logic        st, rd;
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 12);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(st, rd, rpc);
    end
  endtask

  // Monitor: every post-edge snapshot is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("fetch_pc", fetch_pc, e.pc);
        cmp("imem_addr", {21'd0, imem_addr}, (e.pc >> 2) % 2048);
        cmp("dec_valid", {31'd0, dec_valid}, {31'd0, e.valid});
        cmp("dec_pc", dec_pc, e.dpc);
        cmp("dec_pc_inc", dec_pc_inc, e.dinc);
        cmp("dec_inst", dec_inst, e.dinst);
        cmp("misalign_err", {31'd0, misalign_err}, {31'd0, e.err});
`ifdef FETCH_PERF_CNT_EN
        cmp("perf_fetched", perf_fetched, e.pf);
        cmp("perf_squashed", perf_squashed, e.ps);
        cmp("perf_stalled", perf_stalled, e.pt);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk); reset = 1'b0;

    // Sequential fetch from the reset vector.
    step(0, 0, 0);
    cmp("p1_dec_pc", dec_pc, 32'h40);
    cmp("p1_dec_pc_inc", dec_pc_inc, 32'h44);
    cmp("p1_dec_inst", dec_inst, 32'h11110010);
    step(0, 0, 0);

    // Three-cycle stall holding PC 0x48.
    repeat (3) begin
      step(1, 0, 0);
      cmp("p2_hold_fetch_pc", fetch_pc, 32'h48);
      cmp("p2_hold_dec_pc", dec_pc, 32'h44);
    end
    step(0, 0, 0);
    cmp("p2_resume_dec_pc", dec_pc, 32'h48);

    // Redirect wins over a simultaneous stall.
    step(1, 1, 32'h100);
    cmp("p3_fetch_pc", fetch_pc, 32'h100);
    cmp("p3_bubble_valid", {31'd0, dec_valid}, 32'd0);
    step(0, 0, 0);
    cmp("p3_target_dec_pc", dec_pc, 32'h100);

    // Misaligned target: aligned PC, sticky error.
    step(0, 1, 32'h203);
    cmp("p4_fetch_pc", fetch_pc, 32'h200);
    repeat (10) step(0, 0, 0);
    cmp("p4_sticky_err", {31'd0, misalign_err}, 32'd1);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFFFFFC);
    step(0, 0, 0);
    cmp("p5_dec_pc", dec_pc, 32'hFFFFFFFC);
    cmp("p5_dec_pc_inc", dec_pc_inc, 32'h0);
    cmp("p5_fetch_pc", fetch_pc, 32'h0);

    // Back-to-back redirects, then a stall during the squash bubble.
    step(0, 1, 32'h300);
    step(0, 1, 32'h400);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    random_steps(150);

    // Asynchronous reset between edges while stalled.
    step(1, 0, 0);
    step(1, 0, 0);
    #1 reset = 1'b1;
    #1 check_reset_values();
    model_reset();
    stall = 1'b0; redirect = 1'b0;
    @(posedge clk); #1 check_reset_values();
    @(negedge clk); reset = 1'b0;

    random_steps(150);

    @(posedge clk); #3;
    if (sb.size() != 0) cmp("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
